// File: rtl/sync1101_pkg.sv
// Shared definitions for the 1101 sync-word link: transmitter, detector and destuffing receiver.
package sync1101_pkg;

  localparam logic [3:0] SYNC_WORD  = 4'b1101;
  localparam logic [2:0] STUFF_TRIG = 3'b110;
  localparam int unsigned SYNC_LEN  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HDR   = 2'd1,
    DATA  = 2'd2,
    STUFF = 2'd3
  } tx_state_e;

  // Line history after one more bit goes out.
  function automatic logic [2:0] shift_hist(input logic [2:0] hist, input logic bit_out);
    return {hist[1:0], bit_out};
  endfunction

endpackage

// File: rtl/sync1101_tx.sv
// Serial 1101-sync frame transmitter: header, then zero-stuffed payload MSB-first; first bit one cycle after accept.
// Backpressure: in_ready is high only in IDLE; valid_in/data_in are ignored for the whole frame.
module sync1101_tx
  import sync1101_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] data_in,
  input  logic         valid_in,
  output logic         in_ready,
  output logic         tx_bit,
  output logic         tx_en,
  output logic         frame_done
);

  localparam int PW = $clog2(W + 1);
  localparam logic [PW-1:0] PAY_FULL = PW'(W);

  tx_state_e      state_q, state_d;
  logic [W-1:0]   data_q, data_d;
  logic [1:0]     hdr_idx_q, hdr_idx_d;
  logic [PW-1:0]  pay_idx_q, pay_idx_d;
  logic [2:0]     hist_q, hist_d;
  logic           tx_bit_q, tx_bit_d;
  logic           tx_en_q, tx_en_d;
  logic           frame_done_q, frame_done_d;
  logic           in_ready_q, in_ready_d;
  logic           next_payload;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      data_q       <= '0;
      hdr_idx_q    <= '0;
      pay_idx_q    <= '0;
      hist_q       <= '0;
      tx_bit_q     <= 1'b0;
      tx_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      hdr_idx_q    <= hdr_idx_d;
      pay_idx_q    <= pay_idx_d;
      hist_q       <= hist_d;
      tx_bit_q     <= tx_bit_d;
      tx_en_q      <= tx_en_d;
      frame_done_q <= frame_done_d;
      in_ready_q   <= in_ready_d;
    end
  end

  // state_q names the kind of bit currently on the line; this block picks the next one.
  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    hdr_idx_d    = hdr_idx_q;
    pay_idx_d    = pay_idx_q;
    hist_d       = hist_q;
    tx_bit_d     = 1'b0;
    tx_en_d      = 1'b0;
    frame_done_d = 1'b0;
    in_ready_d   = 1'b0;
    next_payload = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        hist_d     = '0;
        hdr_idx_d  = '0;
        pay_idx_d  = '0;
        if (valid_in && in_ready_q) begin
          data_d     = data_in;
          state_d    = HDR;
          tx_en_d    = 1'b1;
          tx_bit_d   = SYNC_WORD[3];
          hist_d     = shift_hist(3'b000, SYNC_WORD[3]);
          in_ready_d = 1'b0;
        end
      end
      HDR: begin
        if (hdr_idx_q != 2'd3) begin
          hdr_idx_d = hdr_idx_q + 2'd1;
          tx_en_d   = 1'b1;
          tx_bit_d  = SYNC_WORD[2'd2 - hdr_idx_q];
          hist_d    = shift_hist(hist_q, SYNC_WORD[2'd2 - hdr_idx_q]);
        end else begin
          next_payload = 1'b1;
        end
      end
      DATA, STUFF: begin
        if (frame_done_q) begin
          state_d    = IDLE;
          in_ready_d = 1'b1;
          hist_d     = '0;
          hdr_idx_d  = '0;
          pay_idx_d  = '0;
        end else begin
          next_payload = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (next_payload) begin
      tx_en_d = 1'b1;
      if (hist_q == STUFF_TRIG) begin
        // A stuffed 0 leaves hist at 100, so it is final exactly when the payload is exhausted.
        state_d      = STUFF;
        tx_bit_d     = 1'b0;
        hist_d       = shift_hist(hist_q, 1'b0);
        frame_done_d = (pay_idx_q == PAY_FULL);
      end else begin
        state_d      = DATA;
        tx_bit_d     = data_q[W-1];
        data_d       = data_q << 1;
        pay_idx_d    = pay_idx_q + PW'(1);
        hist_d       = shift_hist(hist_q, data_q[W-1]);
        frame_done_d = (pay_idx_d == PAY_FULL) && (hist_d != STUFF_TRIG);
      end
    end
  end

  assign in_ready   = in_ready_q;
  assign tx_bit     = tx_bit_q;
  assign tx_en      = tx_en_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sync1101_tx.sv
// Bench for sync1101_tx: directed frames, expected bit streams queued on accept, checked by a negedge monitor.
module tb_sync1101_tx;
  import sync1101_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] data_in = '0;
  logic         valid_in = 1'b0;
  logic         in_ready, tx_bit, tx_en, frame_done;

  always #5 clk = ~clk;

  sync1101_tx #(.W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .in_ready   (in_ready),
    .tx_bit     (tx_bit),
    .tx_en      (tx_en),
    .frame_done (frame_done)
  );

  typedef struct {
    logic [31:0] bits;
    int          len;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   frames_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor with an independent 1101 detector on the framed bit stream.
  logic [31:0] cap = '0;
  int          cap_len = 0;
  int          det_cnt = 0;
  logic [2:0]  dh = '0;
  logic        prev_done = 1'b0;
  exp_t        e;

  always @(negedge clk) begin
    if (rst) begin
      cap = '0; cap_len = 0; det_cnt = 0; dh = '0; prev_done = 1'b0;
    end else begin
      if (prev_done) check("idle_gap_after_done", tx_en, 1'b0);
      prev_done = frame_done;
      if (frame_done) check("done_with_en", tx_en, 1'b1);
      if (tx_en) begin
        if ({dh, tx_bit} == SYNC_WORD) det_cnt++;
        dh = {dh[1:0], tx_bit};
        cap = {cap[30:0], tx_bit};
        cap_len++;
        check("ready_low_while_busy", in_ready, 1'b0);
      end else begin
        dh = '0;
        check("idle_line_zero", tx_bit, 1'b0);
      end
      if (frame_done) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_frame: got frame of %0d bits 0x%0h, expected none", cap_len, cap);
        end else begin
          e = exp_q.pop_front();
          check("frame_len", cap_len, e.len);
          check("frame_bits", cap, e.bits);
          check("det_once", det_cnt, 1);
          frames_seen++;
        end
        cap = '0; cap_len = 0; det_cnt = 0;
      end
    end
  end

  task automatic send(input logic [7:0] w, input logic [31:0] bits, input int len, input bit expect_frame);
    int g;
    g = 0;
    data_in  = w;
    valid_in = 1'b1;
    while (!in_ready && g < 100) begin
      @(posedge clk); #1; g++;
    end
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: got in_ready=0 after %0d cycles, expected 1", g);
      valid_in = 1'b0;
      return;
    end
    if (expect_frame) exp_q.push_back('{bits, len});
    @(posedge clk); #1;
    valid_in = 1'b0;
    data_in  = 8'h5A;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || tx_en) && g < 300) begin
      @(posedge clk); #1; g++;
    end
    if (g >= 300) begin
      n_cmp++; n_bad++;
      $display("FAIL idle_timeout: got %0d frames pending, expected 0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int accepts;
    int g;
    int frames_before;

    repeat (2) @(posedge clk);
    #1;
    check("rst_tx_en", tx_en, 1'b0);
    check("rst_tx_bit", tx_bit, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_release", in_ready, 1'b1);

    send(8'h00, 32'b1101_00000000, 12, 1'b1);
    wait_idle();
    send(8'hDD, 32'b1101_1100111001, 14, 1'b1);
    wait_idle();
    send(8'h06, 32'b1101_00000110_0, 13, 1'b1);
    wait_idle();

    // Abort while payload bit 3 (frame bit 7) is on the line.
    send(8'hFF, 32'b0, 0, 1'b0);
    repeat (6) begin @(posedge clk); #1; end
    check("pre_abort_tx_en", tx_en, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_tx_en", tx_en, 1'b0);
    check("abort_tx_bit", tx_bit, 1'b0);
    check("abort_in_ready", in_ready, 1'b1);
    check("abort_no_done", frame_done, 1'b0);
    send(8'hA5, 32'b1101_100100101, 13, 1'b1);
    wait_idle();

    // Back-to-back frames with valid held and data toggling every cycle.
    frames_before = frames_seen;
    accepts  = 0;
    g        = 0;
    valid_in = 1'b1;
    data_in  = 8'h00;
    while (accepts < 4 && g < 200) begin
      if (in_ready) begin
        if (data_in == 8'h00) exp_q.push_back('{32'b1101_00000000, 12});
        else                  exp_q.push_back('{32'b1101_11111111, 12});
        accepts++;
      end
      @(posedge clk); #1; g++;
      data_in = ~data_in;
    end
    valid_in = 1'b0;
    wait_idle();
    check("b2b_frame_count", frames_seen - frames_before, 4);

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
